alram_lat_clr: RTL

- Single-clock, parametrised RAM with selectable read latency, a read-valid tag, and a selectable read-during-write policy.
- Has a built-in clear engine that zero-fills the array after reset or on request.
- Generalises the fixed two-cycle registered-read RAM wrappers.
- Used by the ECC core for scratch, coefficient and state buffers that need a known-zero start and pipelined reads.

---
 rtl/alram_pkg.sv | 22 ++
 rtl/alram_lat_pipe.sv | 49 ++++
 rtl/alram_lat_clr.sv | 174 +++++++++++++++++
 3 files changed

// File: rtl/alram_pkg.sv
// Shared definitions for the latency-selectable, self-clearing RAM.
// Holds the clear-engine state encoding, the legal read-latency window
// and the read-during-write policy codes.
package alram_pkg;

    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_CLEAR = 1'b1
    } alram_state_e;

    localparam int LAT_MIN = 32'sd1;
    localparam int LAT_MAX = 32'sd4;

    localparam int RDW_OLD = 32'sd0;
    localparam int RDW_NEW = 32'sd1;

    // True when a requested read latency can be built by the pipeline.
    function automatic logic lat_legal(input int lat);
        return (lat >= LAT_MIN) && (lat <= LAT_MAX);
    endfunction

endpackage

// File: rtl/alram_lat_pipe.sv
// Valid+data delay line placed behind the array read register.
// DEPTH stages; valid bits clear on reset, data stages only load when the
// word entering them is valid so the last stage holds its value between reads.
module alram_lat_pipe
#(
    parameter int WID   = 256,
    parameter int DEPTH = 1
)(
    input  logic           clk,
    input  logic           rst,
    input  logic           in_vld,
    input  logic [WID-1:0] in_data,
    output logic           out_vld,
    output logic [WID-1:0] out_data
);

    if (DEPTH == 0) begin : g_pass
        assign out_vld  = in_vld;
        assign out_data = in_data;
    end else begin : g_pipe
        logic [DEPTH-1:0] vld_r;
        logic [WID-1:0]   data_r [DEPTH];

        // Shift valid tags every cycle; move data only alongside a valid tag.
        always_ff @(posedge clk or negedge rst) begin
            if (!rst) begin
                vld_r <= '0;
                for (int i = 0; i < DEPTH; i++) begin
                    data_r[i] <= '0;
                end
            end else begin
                vld_r[0] <= in_vld;
                if (in_vld) begin
                    data_r[0] <= in_data;
                end
                for (int i = 1; i < DEPTH; i++) begin
                    vld_r[i] <= vld_r[i-1];
                    if (vld_r[i-1]) begin
                        data_r[i] <= data_r[i-1];
                    end
                end
            end
        end

        assign out_vld  = vld_r[DEPTH-1];
        assign out_data = data_r[DEPTH-1];
    end

endmodule

// File: rtl/alram_lat_clr.sv
// Single-clock RAM with LAT-cycle pipelined reads tagged by rvld, a
// selectable read-during-write policy, and a clear engine that zero-fills
// the array after reset and whenever clr is pulsed. While the sweep runs
// (busy=1) user reads and writes are dropped.
module alram_lat_clr
    import alram_pkg::*;
#(
    parameter int WID      = 256,
    parameter int AWID     = 5,
    parameter int DEP      = 32'sd1 << AWID,
    parameter int LAT      = 2,
    parameter int RDW      = 0,
    parameter int INIT_CLR = 1
)(
    input  logic            clk,
    input  logic            rst,
    input  logic [AWID-1:0] ra,
    input  logic            re,
    output logic [WID-1:0]  rdo,
    output logic            rvld,
    input  logic [AWID-1:0] wa,
    input  logic [WID-1:0]  wdi,
    input  logic            we,
    input  logic            clr,
    output logic            busy
);

    // Reject latencies the pipeline cannot build and depths the address cannot span.
    if (!lat_legal(LAT) || (DEP < 1) || (DEP > (32'sd1 << AWID))) begin : g_param_err
        $error("alram_lat_clr: illegal LAT or DEP parameter");
    end

    localparam int              PIPE_DEPTH = LAT - 1;
    localparam logic [AWID:0]   DEP_W      = (AWID+1)'(DEP);
    localparam logic [AWID-1:0] LAST_A     = AWID'(DEP - 1);

    logic [WID-1:0]  mem_r [DEP];

    alram_state_e    st_r;
    alram_state_e    st_nxt_s;
    logic [AWID-1:0] cnt_r;
    logic [AWID-1:0] cnt_nxt_s;
    logic            busy_r;

    logic            idle_s;
    logic            ra_in_range_s;
    logic            wa_in_range_s;

    logic            mem_we_s;
    logic [AWID-1:0] mem_wa_s;
    logic [WID-1:0]  mem_wd_s;

    logic            rd_req_s;
    logic [WID-1:0]  rd_data_s;
    logic            rd_vld_r;
    logic [WID-1:0]  rd_data_r;

    assign idle_s        = (st_r == ST_IDLE);
    assign ra_in_range_s = ({1'b0, ra} < DEP_W);
    assign wa_in_range_s = ({1'b0, wa} < DEP_W);
    assign rd_req_s      = idle_s & re;

    // Clear engine: IDLE/CLEAR sequencing and sweep address generation.
    always_comb begin
        st_nxt_s  = st_r;
        cnt_nxt_s = cnt_r;
        case (st_r)
            ST_IDLE: begin
                if (clr) begin
                    st_nxt_s  = ST_CLEAR;
                    cnt_nxt_s = '0;
                end else begin
                    st_nxt_s  = ST_IDLE;
                    cnt_nxt_s = '0;
                end
            end
            ST_CLEAR: begin
                if (clr) begin
                    // A new request restarts the sweep from address zero.
                    st_nxt_s  = ST_CLEAR;
                    cnt_nxt_s = '0;
                end else if (cnt_r == LAST_A) begin
                    st_nxt_s  = ST_IDLE;
                    cnt_nxt_s = '0;
                end else begin
                    st_nxt_s  = ST_CLEAR;
                    cnt_nxt_s = cnt_r + AWID'(1);
                end
            end
            default: begin
                st_nxt_s  = ST_IDLE;
                cnt_nxt_s = '0;
            end
        endcase
    end

    // Array write port: the sweep owns it while clearing, otherwise the user port.
    always_comb begin
        mem_we_s = 1'b0;
        mem_wa_s = '0;
        mem_wd_s = '0;
        if (st_r == ST_CLEAR) begin
            mem_we_s = 1'b1;
            mem_wa_s = cnt_r;
            mem_wd_s = '0;
        end else if (we && wa_in_range_s) begin
            mem_we_s = 1'b1;
            mem_wa_s = wa;
            mem_wd_s = wdi;
        end else begin
            mem_we_s = 1'b0;
        end
    end

    // Read data select: out-of-range reads return zero, same-address write may forward.
    always_comb begin
        rd_data_s = '0;
        if (!ra_in_range_s) begin
            rd_data_s = '0;
        end else if ((RDW == RDW_NEW) && we && (wa == ra)) begin
            rd_data_s = wdi;
        end else begin
            rd_data_s = mem_r[ra];
        end
    end

    // Clear-engine state, sweep counter and registered busy flag.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            st_r   <= (INIT_CLR != 0) ? ST_CLEAR : ST_IDLE;
            cnt_r  <= '0;
            busy_r <= (INIT_CLR != 0);
        end else begin
            st_r   <= st_nxt_s;
            cnt_r  <= cnt_nxt_s;
            busy_r <= (st_nxt_s == ST_CLEAR);
        end
    end

    // Storage array; deliberately not reset, the sweep provides the known-zero state.
    always_ff @(posedge clk) begin
        if (mem_we_s) begin
            mem_r[mem_wa_s] <= mem_wd_s;
        end
    end

    // First read stage: capture the selected word only for accepted reads.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rd_vld_r  <= 1'b0;
            rd_data_r <= '0;
        end else begin
            rd_vld_r <= rd_req_s;
            if (rd_req_s) begin
                rd_data_r <= rd_data_s;
            end
        end
    end

    alram_lat_pipe #(
        .WID   (WID),
        .DEPTH (PIPE_DEPTH)
    ) u_pipe (
        .clk      (clk),
        .rst      (rst),
        .in_vld   (rd_vld_r),
        .in_data  (rd_data_r),
        .out_vld  (rvld),
        .out_data (rdo)
    );

    assign busy = busy_r;

endmodule
